// File: rtl/eespfal_switch_driver_if.sv
// rtl/eespfal_switch_driver_if.sv - request, status, switch-control and rail bundle of the EESPFAL driver
interface eespfal_switch_driver_if #(
  parameter int BIT_SIZE = 64,
  parameter int bits     = 4
);
  logic                start;
  logic [BIT_SIZE-1:0] x_in;
  logic [BIT_SIZE-1:0] k_in;
  logic                busy;
  logic                done;
  logic [BIT_SIZE-1:0] result;
  logic                error;
  logic [bits-1:0]     CLK;
  logic [bits-1:0]     Dis;
  logic                Dis_Phase;
  logic [BIT_SIZE-1:0] x;
  logic [BIT_SIZE-1:0] x_bar;
  logic [BIT_SIZE-1:0] k;
  logic [BIT_SIZE-1:0] k_bar;
  logic [BIT_SIZE-1:0] s;
  logic [BIT_SIZE-1:0] s_bar;

  modport master (
    output start, x_in, k_in, s, s_bar,
    input  busy, done, result, error, CLK, Dis, Dis_Phase, x, x_bar, k, k_bar
  );

  modport slave (
    input  start, x_in, k_in, s, s_bar,
    output busy, done, result, error, CLK, Dis, Dis_Phase, x, x_bar, k, k_bar
  );
endinterface

// File: rtl/eespfal_switch_driver.sv
// rtl/eespfal_switch_driver.sv - EESPFAL switch sequencer: discharge, phased evaluate, capture, recover
module eespfal_switch_driver #(
  parameter int BIT_SIZE     = 64,
  parameter int bits         = 4,
  parameter int DIS_CYCLES   = 4,
  parameter int PHASE_CYCLES = 4
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  eespfal_switch_driver_if.slave bus
);
  localparam int            PW       = $clog2(bits);
  localparam logic [7:0]    DIS_LAST = 8'(DIS_CYCLES - 1);
  localparam logic [7:0]    PH_LAST  = 8'(PHASE_CYCLES - 1);
  localparam logic [PW-1:0] P_LAST   = PW'(bits - 1);

  typedef enum logic [2:0] {IDLE, DISCHARGE, EVAL, CAPTURE, RECOVER, DONE} state_e;

  state_e              state_q, state_d;
  logic [7:0]          c_q, c_d;
  logic [PW-1:0]       p_q, p_d;
  logic [BIT_SIZE-1:0] xl_q, xl_d, kl_q, kl_d, result_q, result_d;
  logic                error_q, error_d, busy_q, busy_d, done_q, done_d, dph_q, dph_d;
  logic [bits-1:0]     clk_q, clk_d, dis_q, dis_d;
  logic [BIT_SIZE-1:0] x_q, x_d, xb_q, xb_d, k_q, k_d, kb_q, kb_d;

  always_comb begin
    state_d  = state_q;
    c_d      = c_q;
    p_d      = p_q;
    xl_d     = xl_q;
    kl_d     = kl_q;
    result_d = result_q;
    error_d  = error_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          xl_d    = bus.x_in;
          kl_d    = bus.k_in;
          error_d = 1'b0;
          c_d     = '0;
          p_d     = '0;
          state_d = DISCHARGE;
        end
      end
      DISCHARGE: begin
        if (c_q == DIS_LAST) begin
          c_d     = '0;
          state_d = EVAL;
        end else begin
          c_d = c_q + 8'd1;
        end
      end
      // EVAL and RECOVER share the same phase/cycle stepping
      EVAL, RECOVER: begin
        if (c_q == PH_LAST) begin
          c_d = '0;
          if (p_q == P_LAST) begin
            p_d     = '0;
            state_d = (state_q == EVAL) ? CAPTURE : DONE;
          end else begin
            p_d = p_q + PW'(1);
          end
        end else begin
          c_d = c_q + 8'd1;
        end
      end
      CAPTURE: begin
        result_d = bus.s;
        if ((bus.s ^ bus.s_bar) != '1) error_d = 1'b1;
        state_d = RECOVER;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    clk_d  = '0;
    dis_d  = '0;
    dph_d  = 1'b0;
    x_d    = '0;
    xb_d   = '0;
    k_d    = '0;
    kb_d   = '0;
    case (state_d)
      DISCHARGE: begin
        dis_d = '1;
        dph_d = 1'b1;
      end
      EVAL: begin
        for (int i = 0; i < bits; i++) clk_d[i] = (i <= int'(p_d));
        x_d  = xl_d;
        xb_d = ~xl_d;
        k_d  = kl_d;
        kb_d = ~kl_d;
      end
      CAPTURE: begin
        clk_d = '1;
        x_d   = xl_d;
        xb_d  = ~xl_d;
        k_d   = kl_d;
        kb_d  = ~kl_d;
      end
      RECOVER: begin
        for (int i = 0; i < bits; i++) clk_d[i] = (i > int'(p_d));
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      c_q      <= '0;
      p_q      <= '0;
      xl_q     <= '0;
      kl_q     <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dph_q    <= 1'b0;
      clk_q    <= '0;
      dis_q    <= '0;
      x_q      <= '0;
      xb_q     <= '0;
      k_q      <= '0;
      kb_q     <= '0;
    end else begin
      state_q  <= state_d;
      c_q      <= c_d;
      p_q      <= p_d;
      xl_q     <= xl_d;
      kl_q     <= kl_d;
      result_q <= result_d;
      error_q  <= error_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dph_q    <= dph_d;
      clk_q    <= clk_d;
      dis_q    <= dis_d;
      x_q      <= x_d;
      xb_q     <= xb_d;
      k_q      <= k_d;
      kb_q     <= kb_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.error     = error_q;
  assign bus.CLK       = clk_q;
  assign bus.Dis       = dis_q;
  assign bus.Dis_Phase = dph_q;
  assign bus.x         = x_q;
  assign bus.x_bar     = xb_q;
  assign bus.k         = k_q;
  assign bus.k_bar     = kb_q;
endmodule

// File: tb/tb_eespfal_switch_driver.sv
// tb/tb_eespfal_switch_driver.sv - self-checking bench for eespfal_switch_driver
module tb_eespfal_switch_driver;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         sel = 1'b0;
  logic         corrupt = 1'b0;
  logic [W-1:0] xin = '0;
  logic [W-1:0] kin = '0;
  logic [W-1:0] cmask;
  int           n_checks = 0;
  int           n_fail = 0;
  logic [W-1:0] prev_res [2];
  logic         prev_err [2];

  always #5 clk = ~clk;

  eespfal_switch_driver_if #(.BIT_SIZE(W), .bits(4)) ifa ();
  eespfal_switch_driver_if #(.BIT_SIZE(W), .bits(4)) ifb ();

  // Switch model: s = x ^ k on the rails, optional bit-5 dual-rail violation
  assign cmask     = corrupt ? 64'h20 : 64'h0;
  assign ifa.start = start & ~sel;
  assign ifb.start = start & sel;
  assign ifa.x_in  = xin;
  assign ifa.k_in  = kin;
  assign ifb.x_in  = xin;
  assign ifb.k_in  = kin;
  assign ifa.s     = (ifa.x ^ ifa.k) & ~cmask;
  assign ifa.s_bar = ~(ifa.x ^ ifa.k) & ~cmask;
  assign ifb.s     = (ifb.x ^ ifb.k) & ~cmask;
  assign ifb.s_bar = ~(ifb.x ^ ifb.k) & ~cmask;

  eespfal_switch_driver #(.BIT_SIZE(W), .bits(4), .DIS_CYCLES(4), .PHASE_CYCLES(4)) dut_a (
    .wb_clk_i(clk), .wb_rst_i(rst), .bus(ifa));
  eespfal_switch_driver #(.BIT_SIZE(W), .bits(4), .DIS_CYCLES(1), .PHASE_CYCLES(1)) dut_b (
    .wb_clk_i(clk), .wb_rst_i(rst), .bus(ifb));

  logic [10:0]  o_ctrl;
  logic         o_done, o_busy, o_err;
  logic [W-1:0] o_x, o_xb, o_k, o_kb, o_res;
  assign o_busy = sel ? ifb.busy : ifa.busy;
  assign o_done = sel ? ifb.done : ifa.done;
  assign o_err  = sel ? ifb.error : ifa.error;
  assign o_res  = sel ? ifb.result : ifa.result;
  assign o_x    = sel ? ifb.x : ifa.x;
  assign o_xb   = sel ? ifb.x_bar : ifa.x_bar;
  assign o_k    = sel ? ifb.k : ifa.k;
  assign o_kb   = sel ? ifb.k_bar : ifa.k_bar;
  assign o_ctrl = sel ? {ifb.busy, ifb.done, ifb.Dis_Phase, ifb.Dis, ifb.CLK}
                      : {ifa.busy, ifa.done, ifa.Dis_Phase, ifa.Dis, ifa.CLK};

  task automatic check(input string nm, input int n, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, n, act, exp);
    end
  endtask

  // Expected {busy, done, Dis_Phase, Dis, CLK} for cycle n after the start-sampling edge
  function automatic logic [10:0] exp_ctrl(input int n, input int dis, input int pc);
    int ev;
    int j;
    ev = 4 * pc;
    if (n < 1) return '0;
    if (n <= dis) return {3'b101, 4'hF, 4'h0};
    if (n <= dis + ev) begin
      j = (n - dis - 1) / pc + 1;
      return {3'b100, 4'h0, 4'((1 << j) - 1)};
    end
    if (n == dis + ev + 1) return {3'b100, 4'h0, 4'hF};
    if (n <= dis + 2 * ev + 1) begin
      j = (n - dis - ev - 2) / pc + 1;
      return {3'b100, 4'h0, 4'((15 << j) & 15)};
    end
    if (n == dis + 2 * ev + 2) return {3'b110, 8'h00};
    return '0;
  endfunction

  task automatic check_cycle(input int n, input int dis, input int pc, input logic [W-1:0] xv,
                             input logic [W-1:0] kv, input logic [W-1:0] er, input logic ee, input int b);
    int  cap;
    bit  on;
    cap = dis + 4 * pc + 1;
    on  = (n > dis) && (n <= cap);
    check("ctrl", n, 64'(o_ctrl), 64'(exp_ctrl(n, dis, pc)));
    check("x", n, o_x, on ? xv : '0);
    check("x_bar", n, o_xb, on ? ~xv : '0);
    check("k", n, o_k, on ? kv : '0);
    check("k_bar", n, o_kb, on ? ~kv : '0);
    check("result", n, o_res, (n <= cap) ? prev_res[b] : er);
    check("error", n, 64'(o_err), 64'((n >= 1 && n <= cap) ? 1'b0 : ee));
  endtask

  task automatic run_op(input int b, input logic [W-1:0] xv, input logic [W-1:0] kv, input bit do_corrupt,
                        input bit hold, input logic [W-1:0] er, input logic ee);
    int dis, pc, lat, cap, done_cnt, done_at;
    bit got;
    dis = b ? 1 : 4;
    pc  = b ? 1 : 4;
    lat = dis + 8 * pc + 2;
    cap = dis + 4 * pc + 1;
    done_cnt = 0;
    done_at = -1;
    @(negedge clk);
    sel = b[0]; start = 1'b1; xin = xv; kin = kv;
    @(posedge clk); #1;
    if (!hold) begin
      start = 1'b0;
      xin = {$urandom, $urandom};
      kin = {$urandom, $urandom};
    end
    for (int n = 1; n <= lat + 1; n++) begin
      corrupt = do_corrupt && (n == cap);
      @(negedge clk);
      check_cycle(n, dis, pc, xv, kv, er, ee, b);
      if (o_done) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
      @(posedge clk); #1;
    end
    corrupt = 1'b0;
    check("latency", 0, 64'(done_at), b ? 64'd11 : 64'd38);
    check("done_count", 0, 64'(done_cnt), 64'd1);
    prev_res[b] = er;
    prev_err[b] = ee;
    if (hold) begin
      // Start was held high throughout: the cycle after DONE must have launched a new operation
      start = 1'b0;
      @(negedge clk);
      check("restart_ctrl", 1, 64'(o_ctrl), 64'(exp_ctrl(1, dis, pc)));
      got = 1'b0;
      for (int i = 0; i < lat + 5; i++) begin
        @(negedge clk);
        if (o_done) begin
          got = 1'b1;
          break;
        end
      end
      check("restart_done", 0, 64'(got), 64'd1);
      @(negedge clk);
      check("restart_idle", 0, 64'(o_ctrl), 64'd0);
      check("restart_result", 0, o_res, xv ^ kv);
      check("restart_error", 0, 64'(o_err), 64'd0);
      prev_res[b] = xv ^ kv;
      prev_err[b] = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] k;
    bit           corrupt;
    bit           hold;
    logic [W-1:0] res;
    logic         err;
  } vec_t;

  vec_t tbl [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] rx, rk, rm;
    int           rb;
    bit           rc;
    bit           seen;

    tbl[0] = '{64'hA5A5_0000_FFFF_1234, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0, 1'b0, 64'hAAAA_0F0F_F0F0_1D3B, 1'b0};
    tbl[1] = '{64'hA5A5_0000_FFFF_1234, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1, 1'b0, 64'hAAAA_0F0F_F0F0_1D1B, 1'b1};
    tbl[2] = '{64'h0000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    tbl[3] = '{64'h1234_5678_9ABC_DEF0, 64'hFFFF_0000_FFFF_0000, 1'b0, 1'b1, 64'hEDCB_5678_6543_DEF0, 1'b0};

    #2 rst = 1'b1;
    #1;
    check("rst_ctrl_a", 0, 64'(ifa.busy) | 64'(ifa.done) | 64'(ifa.CLK) | 64'(ifa.Dis) | 64'(ifa.Dis_Phase), 64'd0);
    check("rst_result_a", 0, ifa.result, 64'd0);
    check("rst_error_a", 0, 64'(ifa.error), 64'd0);
    check("rst_rails_a", 0, ifa.x | ifa.x_bar | ifa.k | ifa.k_bar, 64'd0);
    check("rst_ctrl_b", 0, 64'(ifb.CLK) | 64'(ifb.busy) | 64'(ifb.Dis), 64'd0);
    prev_res[0] = '0; prev_res[1] = '0;
    prev_err[0] = 1'b0; prev_err[1] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int t = 0; t < 4; t++)
      run_op(0, tbl[t].x, tbl[t].k, tbl[t].corrupt, tbl[t].hold, tbl[t].res, tbl[t].err);

    for (int r = 0; r < 6; r++) begin
      rb = int'($urandom_range(0, 1));
      rx = {$urandom, $urandom};
      rk = {$urandom, $urandom};
      rc = 1'($urandom_range(0, 1));
      rm = rc ? 64'h20 : 64'h0;
      run_op(rb, rx, rk, rc, 1'b0, (rx ^ rk) & ~rm, rc);
    end

    // Reset in the 10th EVAL cycle: outputs clear immediately, no done follows
    @(negedge clk);
    sel = 1'b0; start = 1'b1; xin = 64'hDEAD_BEEF_0123_4567; kin = 64'h1111_2222_3333_4444;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (13) @(posedge clk);
    #1;
    check("pre_reset_clk", 14, 64'(ifa.CLK), 64'h7);
    #2 rst = 1'b1;
    #1;
    check("reset_ctrl", 14, 64'(o_ctrl), 64'd0);
    check("reset_rails", 14, o_x | o_xb | o_k | o_kb, 64'd0);
    check("reset_result", 14, o_res, 64'd0);
    check("reset_error", 14, 64'(o_err), 64'd0);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (o_done) seen = 1'b1;
    end
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (o_done || o_busy) seen = 1'b1;
    end
    check("no_done_after_reset", 0, 64'(seen), 64'd0);
    prev_res[0] = '0; prev_res[1] = '0;
    prev_err[0] = 1'b0; prev_err[1] = 1'b0;
    @(posedge clk); #1;
    run_op(0, tbl[0].x, tbl[0].k, 1'b0, 1'b0, tbl[0].res, 1'b0);

    for (int t = 0; t < 3; t++)
      run_op(1, tbl[t].x, tbl[t].k, tbl[t].corrupt, 1'b0, tbl[t].res, tbl[t].err);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
